// File: rtl/spike_readout.sv
// Spike-count readout: accumulates output-neuron spikes over a frame, then runs a
// sequential argmax. Optional live counter read port under SPIKE_READOUT_CNT_RD_EN.
module spike_readout #(
  parameter int IO_WIDTH  = 8,
  parameter int N_OUT     = 10,
  parameter int T_WIDTH   = 5,
  parameter int SC_WIDTH  = 6,
  parameter int CLS_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 CLR,
  input  logic [T_WIDTH-1:0]   T_STEPS,
  input  logic                 IN_VALID,
  input  logic [IO_WIDTH-1:0]  IN_SPIKE,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [CLS_WIDTH-1:0] RES_CLASS,
  output logic [SC_WIDTH-1:0]  RES_COUNT,
  output logic                 RES_TIE,
  output logic                 OVERRUN,
  output logic                 BUSY
`ifdef SPIKE_READOUT_CNT_RD_EN
  ,
  input  logic [CLS_WIDTH-1:0] CNT_RD_IDX,
  output logic [SC_WIDTH-1:0]  CNT_RD_DATA
`endif
);

  localparam int BEATS  = (N_OUT + IO_WIDTH - 1) / IO_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SC_WIDTH-1:0] SC_MAX = {SC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [SC_WIDTH-1:0]  cnt_r [N_OUT];
  logic [BEAT_W-1:0]    beat_r;
  logic [T_WIDTH-1:0]   step_r;
  logic [T_WIDTH-1:0]   tsteps_r;
  logic [CLS_WIDTH-1:0] scan_r;
  logic [CLS_WIDTH-1:0] arg_r;
  logic [SC_WIDTH-1:0]  max_r;
  logic                 tie_r;
  logic                 res_valid_r;
  logic [CLS_WIDTH-1:0] res_class_r;
  logic [SC_WIDTH-1:0]  res_count_r;
  logic                 res_tie_r;
  logic                 overrun_r;
  logic                 busy_r;

  logic                 first_beat_s;
  logic [T_WIDTH-1:0]   t_live_s;
  logic [T_WIDTH-1:0]   t_cur_s;
  logic                 last_beat_s;
  logic                 accept_s;
  logic                 scan_last_s;
  logic [SC_WIDTH-1:0]  scan_cnt_s;
  logic [SC_WIDTH-1:0]  cand_max_s;
  logic [CLS_WIDTH-1:0] cand_arg_s;
  logic                 cand_tie_s;

  // Frame bookkeeping: T_STEPS is taken live on the first beat, latched copy afterwards.
  always_comb begin
    first_beat_s = (beat_r == BEAT_W'(0)) && (step_r == T_WIDTH'(0));
    t_live_s     = (T_STEPS == T_WIDTH'(0)) ? T_WIDTH'(1) : T_STEPS;
    t_cur_s      = first_beat_s ? t_live_s : tsteps_r;
    last_beat_s  = (beat_r == BEAT_W'(BEATS - 1)) && (step_r == (t_cur_s - T_WIDTH'(1)));
    accept_s     = IN_VALID && (state_r == COLLECT);
    scan_last_s  = (scan_r == CLS_WIDTH'(N_OUT - 1));
  end

  // Select the counter currently under scan.
  always_comb begin
    scan_cnt_s = SC_WIDTH'(0);
    for (int n = 0; n < N_OUT; n++) begin
      scan_cnt_s = (scan_r == CLS_WIDTH'(n)) ? cnt_r[n] : scan_cnt_s;
    end
  end

  // Running argmax step: strict greater wins, so the lowest index keeps ties.
  always_comb begin
    cand_max_s = max_r;
    cand_arg_s = arg_r;
    cand_tie_s = tie_r;
    if (scan_r == CLS_WIDTH'(0)) begin
      cand_max_s = scan_cnt_s;
      cand_arg_s = CLS_WIDTH'(0);
      cand_tie_s = 1'b0;
    end else if (scan_cnt_s > max_r) begin
      cand_max_s = scan_cnt_s;
      cand_arg_s = scan_r;
      cand_tie_s = 1'b0;
    end else if (scan_cnt_s == max_r) begin
      cand_max_s = max_r;
      cand_arg_s = arg_r;
      cand_tie_s = 1'b1;
    end else begin
      cand_max_s = max_r;
      cand_arg_s = arg_r;
      cand_tie_s = tie_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      COLLECT: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      SCAN: begin
        if (scan_last_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      HOLD: begin
        if (RES_READY) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_r <= COLLECT;
    end else if (CLR) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counters, frame indices, argmax accumulators and registered result.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int n = 0; n < N_OUT; n++) cnt_r[n] <= SC_WIDTH'(0);
      beat_r      <= BEAT_W'(0);
      step_r      <= T_WIDTH'(0);
      tsteps_r    <= T_WIDTH'(0);
      scan_r      <= CLS_WIDTH'(0);
      arg_r       <= CLS_WIDTH'(0);
      max_r       <= SC_WIDTH'(0);
      tie_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_class_r <= CLS_WIDTH'(0);
      res_count_r <= SC_WIDTH'(0);
      res_tie_r   <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else if (CLR) begin
      for (int n = 0; n < N_OUT; n++) cnt_r[n] <= SC_WIDTH'(0);
      beat_r      <= BEAT_W'(0);
      step_r      <= T_WIDTH'(0);
      tsteps_r    <= T_WIDTH'(0);
      scan_r      <= CLS_WIDTH'(0);
      arg_r       <= CLS_WIDTH'(0);
      max_r       <= SC_WIDTH'(0);
      tie_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_class_r <= CLS_WIDTH'(0);
      res_count_r <= SC_WIDTH'(0);
      res_tie_r   <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != COLLECT);
      if (IN_VALID && (state_r != COLLECT)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        COLLECT: begin
          scan_r <= CLS_WIDTH'(0);
          if (accept_s) begin
            for (int n = 0; n < N_OUT; n++) begin
              if ((beat_r == BEAT_W'(n / IO_WIDTH)) && IN_SPIKE[n % IO_WIDTH] &&
                  (cnt_r[n] != SC_MAX)) begin
                cnt_r[n] <= cnt_r[n] + SC_WIDTH'(1);
              end
            end
            if (first_beat_s) begin
              tsteps_r <= t_live_s;
            end
            if (beat_r == BEAT_W'(BEATS - 1)) begin
              beat_r <= BEAT_W'(0);
              step_r <= last_beat_s ? T_WIDTH'(0) : (step_r + T_WIDTH'(1));
            end else begin
              beat_r <= beat_r + BEAT_W'(1);
            end
          end
        end
        SCAN: begin
          max_r  <= cand_max_s;
          arg_r  <= cand_arg_s;
          tie_r  <= cand_tie_s;
          scan_r <= scan_r + CLS_WIDTH'(1);
          if (scan_last_s) begin
            res_valid_r <= 1'b1;
            res_class_r <= cand_arg_s;
            res_count_r <= cand_max_s;
            res_tie_r   <= cand_tie_s;
          end
        end
        HOLD: begin
          if (RES_READY) begin
            res_valid_r <= 1'b0;
            for (int n = 0; n < N_OUT; n++) cnt_r[n] <= SC_WIDTH'(0);
          end
        end
        default: begin
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign RES_VALID = res_valid_r;
  assign RES_CLASS = res_class_r;
  assign RES_COUNT = res_count_r;
  assign RES_TIE   = res_tie_r;
  assign OVERRUN   = overrun_r;
  assign BUSY      = busy_r;

`ifdef SPIKE_READOUT_CNT_RD_EN
  // Live counter read; indices beyond the last neuron read as zero.
  always_comb begin
    CNT_RD_DATA = SC_WIDTH'(0);
    for (int n = 0; n < N_OUT; n++) begin
      CNT_RD_DATA = (CNT_RD_IDX == CLS_WIDTH'(n)) ? cnt_r[n] : CNT_RD_DATA;
    end
  end
`endif

endmodule

// File: tb/tb_spike_readout.sv
// Directed and randomized checks of spike_readout against a per-neuron spike-count model.
module tb_spike_readout;
  localparam int IO_WIDTH = 8;
  localparam int N_OUT    = 10;

  logic       CLK = 1'b0;
  logic       RSTB;
  logic       CLR;
  logic [4:0] T_STEPS;
  logic       IN_VALID;
  logic [7:0] IN_SPIKE;
  logic       RES_READY;

  logic       res_valid_a, res_tie_a, overrun_a, busy_a;
  logic [3:0] res_class_a;
  logic [5:0] res_count_a;
  logic       res_valid_b, res_tie_b, overrun_b, busy_b;
  logic [3:0] res_class_b;
  logic [3:0] res_count_b;
`ifdef SPIKE_READOUT_CNT_RD_EN
  logic [3:0] cnt_rd_idx;
  logic [5:0] cnt_rd_data_a;
  logic [3:0] cnt_rd_data_b;
`endif

  int errors = 0;
  int checks = 0;
  int model_cnt [N_OUT];

  always #5 CLK = ~CLK;

  spike_readout dut_a (
    .CLK(CLK), .RSTB(RSTB), .CLR(CLR), .T_STEPS(T_STEPS),
    .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE),
    .RES_VALID(res_valid_a), .RES_READY(RES_READY), .RES_CLASS(res_class_a),
    .RES_COUNT(res_count_a), .RES_TIE(res_tie_a), .OVERRUN(overrun_a), .BUSY(busy_a)
`ifdef SPIKE_READOUT_CNT_RD_EN
    , .CNT_RD_IDX(cnt_rd_idx), .CNT_RD_DATA(cnt_rd_data_a)
`endif
  );

  spike_readout #(.SC_WIDTH(4)) dut_b (
    .CLK(CLK), .RSTB(RSTB), .CLR(CLR), .T_STEPS(T_STEPS),
    .IN_VALID(IN_VALID), .IN_SPIKE(IN_SPIKE),
    .RES_VALID(res_valid_b), .RES_READY(RES_READY), .RES_CLASS(res_class_b),
    .RES_COUNT(res_count_b), .RES_TIE(res_tie_b), .OVERRUN(overrun_b), .BUSY(busy_b)
`ifdef SPIKE_READOUT_CNT_RD_EN
    , .CNT_RD_IDX(cnt_rd_idx), .CNT_RD_DATA(cnt_rd_data_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int n = 0; n < N_OUT; n++) model_cnt[n] = 0;
  endtask

  task automatic send_beat(input logic [7:0] s, input int b);
    IN_VALID = 1'b1;
    IN_SPIKE = s;
    tick();
    IN_VALID = 1'b0;
    IN_SPIKE = 8'h00;
    for (int i = 0; i < IO_WIDTH; i++) begin
      if ((b * IO_WIDTH + i) < N_OUT && s[i]) model_cnt[b * IO_WIDTH + i]++;
    end
  endtask

  task automatic send_step(input logic [7:0] b0, input logic [7:0] b1);
    send_beat(b0, 0);
    send_beat(b1, 1);
  endtask

  // Winner = lowest index holding the largest saturated count.
  task automatic model_result(input int sat_max, output int cls, output int cnt, output int tie);
    int s [N_OUT];
    for (int n = 0; n < N_OUT; n++) s[n] = (model_cnt[n] > sat_max) ? sat_max : model_cnt[n];
    cls = 0;
    for (int n = 0; n < N_OUT; n++) if (s[n] > s[cls]) cls = n;
    cnt = s[cls];
    tie = 0;
    for (int n = 0; n < N_OUT; n++) if (n != cls && s[n] == cnt) tie = 1;
  endtask

  task automatic wait_and_check(input string tag);
    int k;
    int cls, cnt, tie;
    k = 0;
    check({tag, "_busy"}, busy_a, 1);
    while (res_valid_a !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, N_OUT);
    model_result(63, cls, cnt, tie);
    check({tag, "_class"}, res_class_a, cls);
    check({tag, "_count"}, res_count_a, cnt);
    check({tag, "_tie"}, res_tie_a, tie);
  endtask

  task automatic handshake(input string tag);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    model_clear();
    check({tag, "_valid_drop"}, res_valid_a, 0);
    check({tag, "_busy_drop"}, busy_a, 0);
  endtask

  initial begin
    int cls, cnt, tie, k, t, eff;
    RSTB = 1'b0; CLR = 1'b0; T_STEPS = 5'd4;
    IN_VALID = 1'b0; IN_SPIKE = 8'h00; RES_READY = 1'b0;
`ifdef SPIKE_READOUT_CNT_RD_EN
    cnt_rd_idx = 4'd0;
`endif
    model_clear();
    tick(); tick();
    check("rst_valid", res_valid_a, 0);
    check("rst_class", res_class_a, 0);
    check("rst_count", res_count_a, 0);
    check("rst_tie", res_tie_a, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_busy", busy_a, 0);
    RSTB = 1'b1;
    tick();

    // 1: neuron 3 every step, neuron 7 in steps 0-1
    T_STEPS = 5'd4;
    send_step(8'h88, 8'h00); send_step(8'h88, 8'h00);
    send_step(8'h08, 8'h00); send_step(8'h08, 8'h00);
    wait_and_check("t1");
    check("t1_class_const", res_class_a, 3);
    check("t1_count_const", res_count_a, 4);
`ifdef SPIKE_READOUT_CNT_RD_EN
    cnt_rd_idx = 4'd7; #1;
    check("t1_rd7", cnt_rd_data_a, 2);
    cnt_rd_idx = 4'd12; #1;
    check("t1_rd12", cnt_rd_data_a, 0);
`endif
    handshake("t1");

    // 2: tie between neurons 2 and 9; T_STEPS change mid-frame ignored
    T_STEPS = 5'd3;
    send_beat(8'h04, 0);
    T_STEPS = 5'd7;
    send_beat(8'h02, 1);
    send_step(8'h04, 8'h02); send_step(8'h04, 8'h02);
    wait_and_check("t2");
    check("t2_tie_const", res_tie_a, 1);
    handshake("t2");

    // 3: saturation in the 4-bit-counter instance
    T_STEPS = 5'd20;
    for (int s = 0; s < 20; s++) send_step(8'h20, 8'h00);
    wait_and_check("t3");
    model_result(15, cls, cnt, tie);
    check("t3b_valid", res_valid_b, 1);
    check("t3b_count", res_count_b, cnt);
    check("t3b_count_const", res_count_b, 15);
    check("t3b_class", res_class_b, cls);
    check("t3b_tie", res_tie_b, tie);

    // 4: beat in HOLD and on the handshake edge is dropped
    IN_VALID = 1'b1; IN_SPIKE = 8'h01;
    tick();
    IN_VALID = 1'b0; IN_SPIKE = 8'h00;
    check("t4_overrun", overrun_a, 1);
    check("t4_hold_valid", res_valid_a, 1);
    check("t4_hold_class", res_class_a, 5);
    check("t4_hold_count", res_count_a, 20);
    IN_VALID = 1'b1; IN_SPIKE = 8'h01;
    handshake("t4");
    IN_VALID = 1'b0; IN_SPIKE = 8'h00;
    T_STEPS = 5'd1;
    send_step(8'h01, 8'h00);
    wait_and_check("t4n");
    check("t4n_count_const", res_count_a, 1);
    handshake("t4n");
    check("t4_overrun_sticky", overrun_a, 1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("t4_overrun_clr", overrun_a, 0);
    check("t4_count_clr", res_count_a, 0);

    // CLR mid-scan: no result appears
    T_STEPS = 5'd1;
    send_step(8'h01, 8'h00);
    tick(); tick();
    CLR = 1'b1; tick(); CLR = 1'b0;
    model_clear();
    k = 0;
    while (res_valid_a !== 1'b1 && k < 15) begin tick(); k++; end
    check("clr_scan_no_result", res_valid_a, 0);
    check("clr_scan_busy", busy_a, 0);

    // Leave a nonzero result registered before the mid-frame reset
    T_STEPS = 5'd1;
    send_step(8'h02, 8'h00);
    wait_and_check("pre5");
    handshake("pre5");

    // 5: reset mid-frame, then a clean frame
    T_STEPS = 5'd4;
    send_step(8'h40 | 8'($urandom), 8'($urandom));
    send_step(8'h40 | 8'($urandom), 8'($urandom));
    RSTB = 1'b0;
    #1;
    check("t5_rst_count", res_count_a, 0);
    check("t5_rst_class", res_class_a, 0);
    check("t5_rst_busy", busy_a, 0);
    tick();
    RSTB = 1'b1;
    model_clear();
    for (int s = 0; s < 4; s++) send_step(8'h40, 8'h00);
    wait_and_check("t5");
    check("t5_count_const", res_count_a, 4);
    handshake("t5");

    // 6: only out-of-range bits set
    T_STEPS = 5'd1;
    send_step(8'h00, 8'hFC);
    wait_and_check("t6");
    check("t6_tie_const", res_tie_a, 1);
    handshake("t6");

    // Randomized frames, including T_STEPS=0
    for (int f = 0; f < 8; f++) begin
      t = $urandom_range(0, 5);
      eff = (t == 0) ? 1 : t;
      T_STEPS = 5'(t);
      for (int s = 0; s < eff; s++) send_step(8'($urandom), 8'($urandom));
      wait_and_check($sformatf("rnd%0d", f));
      handshake($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spike_readout.md
Name: spike_readout

Overview:
- Sits directly downstream of the 5-layer spiking network and consumes its OUT_VALID/OUT_SPIKE stream.
- Counts output-neuron spikes over one inference frame of T_STEPS timesteps.
- Then selects the winning neuron with a sequential argmax and presents the class result on a valid/ready interface.

Parameters:
IO_WIDTH, 8, spike beat width; matches network output width
N_OUT, 10, number of output neurons (classes); beats per timestep BEATS = ceil(N_OUT/IO_WIDTH)
T_WIDTH, 5, width of T_STEPS
SC_WIDTH, 6, per-neuron spike counter width (saturating)
CLS_WIDTH, 4, class index width; must satisfy 2^CLS_WIDTH >= N_OUT

Ports:
CLK  input  1  clock
RSTB  input  1  reset, asynchronous, active-low
CLR  input  1  synchronous clear, highest priority after reset
T_STEPS  input  T_WIDTH  timesteps per frame; 0 treated as 1
IN_VALID  input  1  spike beat valid (from network OUT_VALID)
IN_SPIKE  input  IO_WIDTH  spike beat (from network OUT_SPIKE)
RES_VALID  output  1  result valid
RES_READY  input  1  result consumer ready
RES_CLASS  output  CLS_WIDTH  winning neuron index
RES_COUNT  output  SC_WIDTH  spike count of winner
RES_TIE  output  1  at least one other neuron equals the winner's count
OVERRUN  output  1  sticky: a beat arrived while not collecting
BUSY  output  1  high in SCAN or HOLD

Behaviour:
- Reset: state COLLECT; all counters, beat index and step index 0; RES_VALID, RES_CLASS, RES_COUNT, RES_TIE, OVERRUN and BUSY all 0.
- CLR=1 at an edge: same effect as reset.
- Beat mapping: beat b of a timestep carries neurons b*IO_WIDTH+i on bit i; bits mapping to neuron index >= N_OUT are ignored.
- COLLECT, each IN_VALID edge:
  - Each set, in-range bit increments its neuron counter; counters saturate at 2^SC_WIDTH-1.
  - Beat index advances; after BEATS beats it wraps to 0 and the step index increments.
- T_STEPS is latched on the first beat of a frame; later changes do not affect the current frame.
- The edge accepting the final beat of step T_STEPS-1 moves to SCAN with scan index 0.
- SCAN, one neuron per cycle, index 0..N_OUT-1:
  - Count strictly greater than the running max: replaces it and clears the tie flag.
  - Count equal to the running max at index > 0: sets the tie flag.
  - Lowest index wins ties.
  - The edge processing index N_OUT-1 moves to HOLD and registers RES_*; RES_VALID is high exactly N_OUT cycles after the final-beat edge.
- All counts zero: RES_CLASS=0, RES_COUNT=0, RES_TIE=1 (N_OUT>1).
- HOLD: RES_VALID=1 and RES_* stable until RES_VALID&RES_READY. On that edge: RES_VALID goes to 0, counters clear, state returns to COLLECT.
- IN_VALID in SCAN or HOLD, including the handshake edge: beat dropped, OVERRUN set; it stays set until CLR or reset.
- BUSY=1 in SCAN and HOLD.
- Reset or CLR mid-frame or mid-scan: partial counts discarded; no result is produced.

Optional Feature:
SPIKE_READOUT_CNT_RD_EN
- Defined: adds input CNT_RD_IDX[CLS_WIDTH-1:0] and output CNT_RD_DATA[SC_WIDTH-1:0].
  - CNT_RD_DATA is a combinational read of the live counter for that index.
  - Reads 0 for index >= N_OUT.
  - Counters hold their values through HOLD and are readable there.
- Undefined: both ports absent; behaviour otherwise identical.

Test Plan:
1. Defaults, T_STEPS=4, 8 beats. Neuron 3 spikes every step (beat0=8'h08), neuron 7 in steps 0-1, beat1=8'h00 -> RES_CLASS=3, RES_COUNT=4, RES_TIE=0, RES_VALID exactly 10 cycles after the last beat edge.
2. T_STEPS=3. Neurons 2 and 9 spike every step (beat0=8'h04, beat1=8'h02) -> RES_CLASS=2, RES_COUNT=3, RES_TIE=1.
3. SC_WIDTH=4, T_STEPS=20, neuron 5 every step -> RES_COUNT=15 (saturated), RES_CLASS=5.
4. RES_READY held low in HOLD, one IN_VALID beat sent -> OVERRUN=1 and RES_* unchanged. Then RES_READY=1 -> RES_VALID=0, next frame (T=1, neuron 0) gives RES_CLASS=0, RES_COUNT=1. OVERRUN stays 1 until CLR.
5. T_STEPS=4; after 2 steps RSTB pulsed low -> all outputs 0 immediately. Fresh 4-step frame with neuron 6 every step -> RES_COUNT=4, no residue from the aborted frame.
6. T_STEPS=1, beat0=8'h00, beat1=8'hFC (neurons 10-15 only) -> all counts 0, RES_CLASS=0, RES_COUNT=0, RES_TIE=1.
